// File: rtl/interp_block_sequencer.sv
// -----------------------------------------------------------------------------
// interp_block_sequencer
//   Sequences one 8x8 luma block through the row-serial subpixel interpolation
//   datapath: accepts reference rows (full fill of NUM_PIXEL+TAPS-1 rows, or an
//   incremental fill of NUM_PIXEL rows reusing the halo), issues the input
//   buffer and horizontal-result load strobes, then drains the a/b/c vertical
//   results to the sink as 3*NUM_PIXEL beats.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   begin a block (sampled in IDLE only)
//   new_frame  in   sampled with start: 1 = full fill, 0 = reuse halo rows
//   in_valid   in   source row present
//   in_ready   out  sequencer accepts a row this cycle
//   load_in    out  in_valid & in_ready; shifts row into the input buffer
//   load_L     out  horizontal FIR result valid (load_in delayed PIPE_LAT)
//   row_idx    out  index of the row being accepted
//   out_valid  out  vertical result beat valid
//   out_ready  in   sink accepts beat
//   out_phase  out  fractional position of the current beat (0=a,1=b,2=c)
//   out_row    out  output row of the current beat
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module interp_block_sequencer #(
   parameter int unsigned NUM_PIXEL = 8,
   parameter int unsigned TAPS      = 8,
   parameter int unsigned PIPE_LAT  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       new_frame,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       load_in,
   output logic       load_L,
   output logic [3:0] row_idx,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_phase,
   output logic [2:0] out_row,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [3:0] ROW_LAST_FULL = 4'(NUM_PIXEL + TAPS - 2);
   localparam logic [3:0] ROW_LAST_INC  = 4'(NUM_PIXEL - 1);
   localparam logic [3:0] HALO_ROWS     = 4'(TAPS - 1);
   localparam logic [4:0] BEAT_LAST     = 5'(3 * NUM_PIXEL - 1);
   localparam logic [3:0] FLUSH_LAST    = 4'(PIPE_LAT - 1);

   state_t                state, next_state;
   logic                  first;
   logic                  no_prior_block;
   logic [4:0]            k;
   logic [3:0]            flush_cnt;
   logic [PIPE_LAT-1:0]   load_line;
   logic [3:0]            row_last;
   logic                  halo_row;

   assign row_last = first ? ROW_LAST_FULL : ROW_LAST_INC;
   // In a full fill the leading TAPS-1 rows only prime the vertical filter.
   assign halo_row = first && (row_idx < HALO_ROWS);
   assign load_in  = in_valid & in_ready;
   assign load_L   = load_line[PIPE_LAT-1];

   assign out_phase = out_valid ? 2'(k / 5'(NUM_PIXEL)) : '0;
   assign out_row   = out_valid ? 3'(k % 5'(NUM_PIXEL)) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   // Ready/valid are pure state decodes; handshakes only steer next_state.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) next_state = S_FILL;
         end
         S_FILL: begin
            in_ready = 1'b1;
            if (in_valid && (row_idx == row_last)) next_state = S_FLUSH;
         end
         S_FLUSH: begin
            if (flush_cnt == FLUSH_LAST) next_state = S_DRAIN;
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && (k == BEAT_LAST)) next_state = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: begin
            busy       = 1'b0;
            next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         first          <= 1'b0;
         no_prior_block <= 1'b1;
         row_idx        <= '0;
         k              <= '0;
         flush_cnt      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  first     <= new_frame | no_prior_block;
                  row_idx   <= '0;
                  k         <= '0;
                  flush_cnt <= '0;
               end
            end
            S_FILL: begin
               if (load_in && (row_idx != row_last)) row_idx <= row_idx + 4'd1;
            end
            S_FLUSH: begin
               if (flush_cnt != FLUSH_LAST) flush_cnt <= flush_cnt + 4'd1;
            end
            S_DRAIN: begin
               if (out_ready && (k != BEAT_LAST)) k <= k + 5'd1;
            end
            S_DONE: begin
               no_prior_block <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Free-running delay line; keeps shifting through FLUSH so the final
   // horizontal result still emerges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_line <= '0;
      end else begin
         load_line[0] <= load_in & ~halo_row;
         for (int unsigned i = 1; i < PIPE_LAT; i++) load_line[i] <= load_line[i-1];
      end
   end

endmodule

// File: tb/tb_interp_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interp_block_sequencer
//   Directed block sequence with randomized in_valid/out_ready/start noise,
//   checked every cycle against a transaction-level model: rows accepted,
//   scheduled load_L times, beat order and the done cycle.
// -----------------------------------------------------------------------------
module tb_interp_block_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, new_frame, in_valid, out_ready;
   logic       in_ready, load_in, load_L, out_valid, busy, done;
   logic [3:0] row_idx;
   logic [1:0] out_phase;
   logic [2:0] out_row;

   int tests = 0;
   int fails = 0;
   bit m_no_prior = 1'b1;

   always #5 clk = ~clk;

   interp_block_sequencer #(
      .NUM_PIXEL(8),
      .TAPS     (8),
      .PIPE_LAT (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .new_frame(new_frame),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .load_in  (load_in),
      .load_L   (load_L),
      .row_idx  (row_idx),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_phase(out_phase),
      .out_row  (out_row),
      .busy     (busy),
      .done     (done)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, " in_ready"},  {7'd0, in_ready},  8'd0);
      chk({tag, " load_in"},   {7'd0, load_in},   8'd0);
      chk({tag, " load_L"},    {7'd0, load_L},    8'd0);
      chk({tag, " out_valid"}, {7'd0, out_valid}, 8'd0);
      chk({tag, " out_phase"}, {6'd0, out_phase}, 8'd0);
      chk({tag, " out_row"},   {5'd0, out_row},   8'd0);
      chk({tag, " busy"},      {7'd0, busy},      8'd0);
      chk({tag, " done"},      {7'd0, done},      8'd0);
   endtask

   // One block: nf = new_frame with start, vpct/rpct = in_valid/out_ready
   // probabilities, stall_beat = beat held off 5 cycles (-1 none),
   // abort_beat = beat at which reset is asserted (-1 none), noise = random start.
   task automatic run_block(input bit nf, input int vpct, input int rpct,
                            input int stall_beat, input int abort_beat, input bit noise);
      bit first;
      int n, rows, beats, cyc, last_load, done_cyc, stall_left;
      int due[$];
      bit fin, exp_fill, exp_drain, exp_ldl;

      first = nf || m_no_prior;
      n = first ? 15 : 8;
      rows = 0; beats = 0; cyc = 1; last_load = -100; done_cyc = -1;
      stall_left = 5; fin = 1'b0;

      @(posedge clk); #1;
      start = 1'b1; new_frame = nf; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("start busy", {7'd0, busy}, 8'd0);
      chk("start in_ready", {7'd0, in_ready}, 8'd0);
      @(posedge clk); #1;
      start = 1'b0;

      for (int t = 0; t < 3000 && !fin; t++) begin
         in_valid  = ($urandom_range(99) < vpct);
         out_ready = ($urandom_range(99) < rpct);
         if (stall_beat >= 0 && beats == stall_beat && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end
         start     = noise ? 1'($urandom_range(1)) : 1'b0;
         new_frame = 1'($urandom_range(1));
         @(negedge clk);

         exp_fill  = (rows < n);
         exp_drain = (rows == n) && (cyc >= last_load + 3) && (beats < 24);
         exp_ldl   = (due.size() > 0) && (due[0] == cyc);
         if (exp_ldl) void'(due.pop_front());

         if (abort_beat >= 0 && exp_drain && beats == abort_beat) begin
            rst = 1'b0;
            #1;
            chk_idle_zero("abort");
            chk("abort row_idx", {4'd0, row_idx}, 8'd0);
            start = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("abort no done", {7'd0, done}, 8'd0);
            end
            rst = 1'b1;
            m_no_prior = 1'b1;
            return;
         end

         chk("in_ready",  {7'd0, in_ready},  {7'd0, exp_fill});
         chk("load_in",   {7'd0, load_in},   {7'd0, exp_fill && in_valid});
         if (exp_fill) chk("row_idx", {4'd0, row_idx}, 8'(rows));
         chk("load_L",    {7'd0, load_L},    {7'd0, exp_ldl});
         chk("out_valid", {7'd0, out_valid}, {7'd0, exp_drain});
         if (exp_drain) begin
            chk("out_phase", {6'd0, out_phase}, 8'(beats / 8));
            chk("out_row",   {5'd0, out_row},   8'(beats % 8));
         end
         chk("done", {7'd0, done}, {7'd0, cyc == done_cyc});
         chk("busy", {7'd0, busy}, 8'd1);

         if (exp_fill && in_valid) begin
            if (!(first && rows < 7)) due.push_back(cyc + 2);
            if (rows == n - 1) last_load = cyc;
            rows++;
         end
         if (exp_drain && out_ready) begin
            beats++;
            if (beats == 24) done_cyc = cyc + 1;
         end
         if (cyc == done_cyc) fin = 1'b1;

         @(posedge clk); #1;
         cyc++;
      end

      chk("block finished in time", {7'd0, fin}, 8'd1);
      chk("due queue empty", 8'(due.size()), 8'd0);
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk_idle_zero("after done");
      m_no_prior = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; new_frame = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk_idle_zero("reset");
      chk("reset row_idx", {4'd0, row_idx}, 8'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Full fill, source and sink always ready.
      run_block(1'b1, 100, 100, -1, -1, 1'b0);
      // Incremental fill reusing halo rows.
      run_block(1'b0, 100, 100, -1, -1, 1'b0);
      // Gappy source.
      run_block(1'b1, 50, 100, -1, -1, 1'b0);
      // Sink stalls beat 9 for 5 cycles.
      run_block(1'b0, 100, 100, 9, -1, 1'b0);
      // Reset mid-drain at beat 12, then new_frame=0 must still refill fully.
      run_block(1'b0, 100, 100, -1, 12, 1'b0);
      run_block(1'b0, 100, 100, -1, -1, 1'b0);
      // Start noise throughout the block.
      run_block(1'b0, 70, 70, -1, -1, 1'b1);
      // Random mix.
      for (int i = 0; i < 4; i++)
         run_block(1'($urandom_range(1)), 40 + int'($urandom_range(60)),
                   40 + int'($urandom_range(60)), -1, -1, 1'($urandom_range(1)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
